// File: rtl/ifetch_prefetch_queue.sv
// Instruction-fetch prefetch queue: issues in-order requests to a variable-latency
// instruction memory and buffers returned words for the IF_ID register.
module ifetch_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        deq_ready,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc_plus4
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = $clog2(DEPTH + 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   w_fetch_pc_next;
  logic [31:0]   r_resp_pc;
  logic [31:0]   w_resp_pc_next;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] w_outstanding_next;
  logic [DW-1:0] r_drop_cnt;
  logic [DW-1:0] w_drop_cnt_next;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;

  logic [31:0]   r_inst_mem [DEPTH];
  logic [31:0]   r_pc4_mem  [DEPTH];

  logic          w_room;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic [DW-1:0] w_drop_on_redirect;

  // Credit check: buffered words plus in-flight requests may never exceed DEPTH.
  assign w_room = ((CW+1)'(r_count) + (CW+1)'(r_outstanding)) < (CW+1)'(DEPTH);

  assign imem_req_valid = (r_state == S_FETCH) && !redirect && w_room;
  assign imem_req_addr  = r_fetch_pc;
  assign w_accept       = imem_req_valid && imem_req_ready;

  assign out_valid    = (r_count != '0);
  assign out_inst     = out_valid ? r_inst_mem[r_rd_ptr] : 32'h0;
  assign out_pc_plus4 = out_valid ? r_pc4_mem[r_rd_ptr]  : 32'h0;

  assign w_push = (r_state == S_FETCH) && imem_resp_valid && !redirect;
  assign w_pop  = out_valid && deq_ready && !redirect;

  // A response arriving in the redirect cycle is already stale, so it is netted out here.
  assign w_drop_on_redirect = DW'(r_outstanding) + DW'(w_accept) - DW'(imem_resp_valid);

  always_comb begin
    w_state_next       = r_state;
    w_fetch_pc_next    = r_fetch_pc;
    w_resp_pc_next     = r_resp_pc;
    w_outstanding_next = r_outstanding;
    w_drop_cnt_next    = r_drop_cnt;
    w_count_next       = r_count + CW'(w_push) - CW'(w_pop);

    case (r_state)
      S_IDLE: begin
        w_state_next = S_FETCH;
      end
      S_FETCH: begin
        if (redirect) begin
          w_drop_cnt_next    = w_drop_on_redirect;
          w_outstanding_next = '0;
          if (w_drop_on_redirect != '0) begin
            w_state_next = S_DRAIN;
          end
        end else begin
          w_outstanding_next = r_outstanding + CW'(w_accept) - CW'(imem_resp_valid);
          if (w_accept) begin
            w_fetch_pc_next = r_fetch_pc + 32'd4;
          end
          if (w_push) begin
            w_resp_pc_next = r_resp_pc + 32'd4;
          end
        end
      end
      S_DRAIN: begin
        if (imem_resp_valid) begin
          w_drop_cnt_next = r_drop_cnt - DW'(1);
        end
        if (w_drop_cnt_next == '0) begin
          w_state_next = S_FETCH;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    if (redirect) begin
      w_fetch_pc_next = redirect_pc;
      w_resp_pc_next  = redirect_pc;
      w_count_next    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      r_state       <= w_state_next;
      r_fetch_pc    <= w_fetch_pc_next;
      r_resp_pc     <= w_resp_pc_next;
      r_count       <= w_count_next;
      r_outstanding <= w_outstanding_next;
      r_drop_cnt    <= w_drop_cnt_next;
      if (redirect) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
      end
    end
  end

  // Storage needs no reset: entries are only visible while r_count says they are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_inst_mem[r_wr_ptr] <= imem_resp_data;
      r_pc4_mem[r_wr_ptr]  <= r_resp_pc + 32'd4;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && !w_pop && (r_count == CW'(DEPTH))));

endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// Randomized scoreboard bench for ifetch_prefetch_queue: a transaction-level model
// (epoch-tagged memory requests, queue of expected words) predicts every output.
`timescale 1ns/1ps
module tb_ifetch_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        deq_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc_plus4;

  ifetch_prefetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .deq_ready       (deq_ready),
    .out_valid       (out_valid),
    .out_inst        (out_inst),
    .out_pc_plus4    (out_pc_plus4)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] epoch;
    logic [31:0] due;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [63:0] exp_q[$];

  int          vectors = 0;
  int          miscompares = 0;
  int unsigned cyc = 0;
  int unsigned epoch = 0;
  int unsigned cur_inflight = 0;
  int unsigned stale_inflight = 0;
  int unsigned edges_since_rst = 0;
  logic        started = 1'b0;
  logic [31:0] model_pc = RESET_PC;
  logic        lat_check = 1'b0;
  logic        seen_valid = 1'b0;
  logic        s_req_valid = 1'b0;

  int phase = 0;
  int step_i = 0;
  int lat_min, lat_max, ready_pct, deq_pct, redir_pct, resp_pct, ncyc;
  int ready0_steps, deq_hold_steps, force_redir_at;

  logic        m_exp_rv;
  logic [63:0] m_head;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (phase %0d cycle %0d)", name, act, exp, phase, cyc);
    end
  endtask

  // Monitor: compares the DUT's pre-edge view against the model and retires dequeues.
  always @(negedge clk) begin
    if (!rst) begin
      m_exp_rv = started && !redirect && (stale_inflight == 0) &&
                 ((cur_inflight + exp_q.size()) < DEPTH);
      check("req_valid", 32'(imem_req_valid), 32'(m_exp_rv));
      if (m_exp_rv) check("req_addr", imem_req_addr, model_pc);
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        m_head = exp_q[0];
        check("out_inst", out_inst, m_head[63:32]);
        check("out_pc_plus4", out_pc_plus4, m_head[31:0]);
        if (deq_ready && !redirect) begin
          void'(exp_q.pop_front());
          $display("phase %0d cycle %0d deq pc+4=%h inst=%h", phase, cyc, m_head[31:0], m_head[63:32]);
        end
      end else begin
        check("idle_inst", out_inst, 32'h0);
        check("idle_pc_plus4", out_pc_plus4, 32'h0);
      end
      if (lat_check && !seen_valid && out_valid) begin
        seen_valid = 1'b1;
        check("first_valid_edges", 32'(edges_since_rst), 32'd3);
      end
    end
  end

  task automatic apply_edge();
    mreq_t r;
    int    lat;
    edges_since_rst++;
    started = 1'b1;
    if (imem_resp_valid) begin
      r = mem_q.pop_front();
      if (r.epoch != 32'(epoch)) begin
        stale_inflight--;
      end else begin
        cur_inflight--;
        if (!redirect) exp_q.push_back({inst_of(r.addr), r.addr + 32'd4});
      end
    end
    if (s_req_valid && imem_req_ready) begin
      lat = $urandom_range(lat_max, lat_min);
      mem_q.push_back('{addr: model_pc, epoch: 32'(epoch), due: 32'(cyc + lat)});
      cur_inflight++;
      model_pc = model_pc + 32'd4;
    end
    if (redirect) begin
      exp_q.delete();
      stale_inflight += cur_inflight;
      cur_inflight = 0;
      epoch++;
      model_pc = redirect_pc;
    end
    cyc++;
  endtask

  task automatic drive();
    logic [31:0] tmp;
    imem_req_ready = (step_i < ready0_steps) ? 1'b0 : ($urandom_range(100, 1) <= ready_pct);
    deq_ready      = (step_i < deq_hold_steps) ? 1'b0 : ($urandom_range(100, 1) <= deq_pct);
    redirect       = started && (($urandom_range(100, 1) <= redir_pct) || (step_i == force_redir_at));
    tmp = $urandom();
    if (step_i == force_redir_at) redirect_pc = 32'h0000_0100;
    else if ($urandom_range(3, 0) == 0) redirect_pc = 32'hFFFF_FFF0 | (tmp & 32'h0000_000C);
    else redirect_pc = tmp & 32'hFFFF_FFFC;
    imem_resp_valid = (mem_q.size() != 0) && (mem_q[0].due <= 32'(cyc)) &&
                      ($urandom_range(100, 1) <= resp_pct);
    imem_resp_data  = imem_resp_valid ? inst_of(mem_q[0].addr) : $urandom();
  endtask

  task automatic step();
    @(negedge clk);
    s_req_valid = imem_req_valid;
    @(posedge clk);
    apply_edge();
    #1;
    drive();
    step_i++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    redirect        = 1'b0;
    deq_ready       = 1'b0;
    mem_q.delete();
    exp_q.delete();
    cur_inflight    = 0;
    stale_inflight  = 0;
    epoch++;
    model_pc        = RESET_PC;
    started         = 1'b0;
    edges_since_rst = 0;
    seen_valid      = 1'b0;
    step_i          = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    for (int p = 0; p < 5; p++) begin
      phase = p;
      lat_min = 1; lat_max = 1; ready_pct = 100; deq_pct = 100; redir_pct = 0; resp_pct = 100;
      ncyc = 30; ready0_steps = 0; deq_hold_steps = 0; force_redir_at = -1;
      case (p)
        0: ncyc = 20;
        1: deq_hold_steps = 10;
        2: begin lat_min = 3; lat_max = 3; force_redir_at = 4; end
        3: begin lat_max = 5; ready_pct = 70; deq_pct = 60; redir_pct = 4; resp_pct = 80; ncyc = 1500; end
        default: begin lat_max = 2; ready0_steps = 5; deq_pct = 0; ncyc = 20; end
      endcase
      lat_check = (p == 0);
      do_reset();
      for (int i = 0; i < ncyc; i++) step();
      if (p == 0) check("first_valid_seen", 32'(seen_valid), 32'd1);
      if (p == 4) begin
        check("pre_rst_out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        #3 rst = 1'b1;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("async_rst_req_addr", imem_req_addr, RESET_PC);
        check("async_rst_out_inst", out_inst, 32'h0);
        check("async_rst_out_pc_plus4", out_pc_plus4, 32'h0);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
